// File: rtl/serial_nor_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_nor_deser_if
//  Description : Handshake bundle for serial_nor_deser. Carries the bit-serial
//                input channel (in_valid/in_ready/in_bit) and the word output
//                channel (out_valid/out_ready/out_word/out_nor).
//  Modports    : slave  - the deserializer side (drives in_ready and outputs)
//                master - the environment side (drives in_valid/in_bit/out_ready)
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_nor_deser_if #(
  parameter int WAY = 3
);
  logic           in_valid;
  logic           in_ready;
  logic           in_bit;
  logic           out_valid;
  logic           out_ready;
  logic [WAY-1:0] out_word;
  logic           out_nor;

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_word, out_nor
  );

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_word, out_nor
  );
endinterface
`default_nettype wire

// File: rtl/serial_nor_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_nor / serial_nor_deser
//  Description : serial_nor   - WAY-input NOR, either a plain reduction
//                               (BEHAVIORAL!=0) or a balanced OR tree.
//                serial_nor_deser - assembles WAY-bit words from a valid/ready
//                               bit stream, holds each finished word under
//                               out_valid/out_ready, and flags all-zero words
//                               through an internal serial_nor.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                clear - synchronous abort of partial and held word
//                bus   - serial_nor_deser_if.slave (stream in, word out)
//  Revision    : 1.0  initial release
// ============================================================================

module serial_nor #(
  parameter int WAY        = 3,
  parameter int BEHAVIORAL = 0
) (
  input  logic [WAY-1:0] in_bits,
  output logic           nor_out
);
  generate
    if (BEHAVIORAL != 0) begin : g_behav
      assign nor_out = ~|in_bits;
    end else begin : g_tree
      // Leaves are padded with zeros up to a power of two so each level is a
      // clean pairwise OR of the level below it.
      localparam int LEVELS = (WAY > 1) ? $clog2(WAY) : 0;

      for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [(1<<l)-1:0] node;
        if (l == LEVELS) begin : g_leaf
          for (genvar i = 0; i < (1 << l); i++) begin : g_pad
            if (i < WAY) begin : g_in
              assign node[i] = in_bits[i];
            end else begin : g_zero
              assign node[i] = 1'b0;
            end
          end
        end else begin : g_or
          for (genvar i = 0; i < (1 << l); i++) begin : g_node
            assign node[i] = g_lvl[l+1].node[2*i] | g_lvl[l+1].node[2*i+1];
          end
        end
      end

      assign nor_out = ~g_lvl[0].node[0];
    end
  endgenerate
endmodule

module serial_nor_deser #(
  parameter int WAY        = 3,
  parameter int BEHAVIORAL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  serial_nor_deser_if.slave  bus
);
  localparam int CW = $clog2(WAY + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [WAY-1:0] sreg, sreg_nxt;
  logic [WAY-1:0] shifted;
  logic           in_ready;
  logic           out_valid;
  logic           accept;
  logic           consume;

  // Shift the incoming bit in at the LSB so the first bit of a word ends up
  // at the MSB once WAY bits have been taken.
  generate
    if (WAY == 1) begin : g_shift_one
      assign shifted = bus.in_bit;
    end else begin : g_shift_multi
      assign shifted = {sreg[WAY-2:0], bus.in_bit};
    end
  endgenerate

  // in_ready depends combinationally on out_ready only, so a held word and
  // the first bit of the next word can change hands in the same cycle.
  assign in_ready  = (state == FILL) | ((state == HOLD) & bus.out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = bus.in_valid & in_ready;
  assign consume   = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    if (clear) begin
      // Abort wins over any handshake seen in this cycle.
      state_nxt = FILL;
      cnt_nxt   = '0;
      sreg_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            sreg_nxt = shifted;
            if (cnt == CW'(WAY - 1)) begin
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (consume) begin
            if (accept) begin
              sreg_nxt = shifted;
              if (WAY == 1) begin
                // A single bit is already a whole word: stay presenting.
                state_nxt = HOLD;
                cnt_nxt   = '0;
              end else begin
                state_nxt = FILL;
                cnt_nxt   = CW'(1);
              end
            end else begin
              // Word leaves; sreg keeps its stale value until new bits arrive.
              state_nxt = FILL;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = FILL;
          cnt_nxt   = '0;
          sreg_nxt  = '0;
        end
      endcase
    end
  end

  serial_nor #(
    .WAY        (WAY),
    .BEHAVIORAL (BEHAVIORAL)
  ) u_nor (
    .in_bits (sreg),
    .nor_out (bus.out_nor)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = sreg;
endmodule
`default_nettype wire
